// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 coefficient path: target register map,
// coefficient width and the coefficient-loader state encoding.
package biquad8_pkg;

    localparam logic [6:0] BQ_ADR_CTRL        = 7'h00;
    localparam logic [6:0] BQ_ADR_COEFF       = 7'h04;
    localparam int         BQ_COEFF_BITS      = 18;
    localparam int         BQ_CTRL_UPDATE_BIT = 0;
    localparam logic [31:0] BQ_CTRL_UPDATE    = 32'h1 << BQ_CTRL_UPDATE_BIT;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_FETCH,
        LD_WRITE,
        LD_GAP,
        LD_UPDATE,
        LD_FINISH
    } loader_state_t;

    // Coefficients are right-aligned and zero-extended onto the 32-bit data bus.
    function automatic logic [31:0] bq_coeff_word(input logic [BQ_COEFF_BITS-1:0] coeff);
        return {{(32-BQ_COEFF_BITS){1'b0}}, coeff};
    endfunction

endpackage

// File: rtl/biquad8_coeff_loader_ack_timer.sv
// Ack watchdog: counts cycles while a bus transaction is outstanding and flags
// the cycle on which the TIMEOUT-th cycle without an ack is reached.
module wb_ack_timer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

    logic [15:0] count_reg;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run && (count_reg != LAST_COUNT)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    // count_reg == k during the (k+1)-th cycle of the transaction
    assign expire = run && (count_reg == LAST_COUNT);

endmodule

// File: rtl/biquad8_coeff_loader.sv
// WISHBONE initiator that streams NCOEFF coefficients into a biquad8 target,
// one single write per coefficient, optionally followed by an update strobe.
module biquad8_coeff_loader
    import biquad8_pkg::*;
#(
    parameter int unsigned NCOEFF    = 8,
    parameter bit          UPDATE_EN = 1'b1,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     start_i,
    input  logic [BQ_COEFF_BITS-1:0] coeff_dat_i,
    input  logic                     coeff_valid_i,
    output logic                     coeff_ready_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [6:0]               wb_adr_o,
    output logic [31:0]              wb_dat_o,
    output logic [3:0]               wb_sel_o,
    input  logic                     wb_ack_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    localparam logic [7:0] NCOEFF_CNT = 8'(NCOEFF);

    loader_state_t state_reg;
    logic [7:0]    count_reg;
    logic          ready_reg;
    logic          cyc_reg;
    logic          we_reg;
    logic [6:0]    adr_reg;
    logic [31:0]   dat_reg;
    logic [3:0]    sel_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_reg;

    logic beat;
    logic in_bus;
    logic timer_expire;

    assign beat   = coeff_valid_i && ready_reg;
    assign in_bus = (state_reg == LD_WRITE) || (state_reg == LD_UPDATE);

    // Timer is held at zero whenever no transaction is outstanding, so every
    // write starts its ack wait from a clean count.
    wb_ack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clear    (!in_bus),
        .run      (in_bus),
        .expire   (timer_expire)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= LD_IDLE;
            count_reg <= '0;
            ready_reg <= 1'b0;
            cyc_reg   <= 1'b0;
            we_reg    <= 1'b0;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                LD_IDLE: begin
                    if (start_i) begin
                        state_reg <= LD_FETCH;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        ready_reg <= 1'b1;
                    end
                end
                LD_FETCH: begin
                    if (beat) begin
                        ready_reg <= 1'b0;
                        adr_reg   <= BQ_ADR_COEFF;
                        dat_reg   <= bq_coeff_word(coeff_dat_i);
                        sel_reg   <= 4'hF;
                        we_reg    <= 1'b1;
                        cyc_reg   <= 1'b1;
                        state_reg <= LD_WRITE;
                    end
                end
                LD_WRITE, LD_UPDATE: begin
                    // An ack on the expiry cycle still wins over the timeout.
                    if (wb_ack_i) begin
                        cyc_reg <= 1'b0;
                        we_reg  <= 1'b0;
                        if (state_reg == LD_WRITE) begin
                            count_reg <= count_reg + 8'd1;
                            state_reg <= LD_GAP;
                        end else begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= LD_FINISH;
                        end
                    end else if (timer_expire) begin
                        cyc_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= LD_IDLE;
                    end
                end
                LD_GAP: begin
                    // One idle bus cycle so the target sees stb fall before the next write.
                    if (count_reg < NCOEFF_CNT) begin
                        ready_reg <= 1'b1;
                        state_reg <= LD_FETCH;
                    end else if (UPDATE_EN) begin
                        adr_reg   <= BQ_ADR_CTRL;
                        dat_reg   <= BQ_CTRL_UPDATE;
                        sel_reg   <= 4'h1;
                        we_reg    <= 1'b1;
                        cyc_reg   <= 1'b1;
                        state_reg <= LD_UPDATE;
                    end else begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= LD_FINISH;
                    end
                end
                LD_FINISH: begin
                    state_reg <= LD_IDLE;
                end
                default: begin
                    state_reg <= LD_IDLE;
                end
            endcase
        end
    end

    assign coeff_ready_o = ready_reg;
    assign wb_cyc_o      = cyc_reg;
    assign wb_stb_o      = cyc_reg;
    assign wb_we_o       = we_reg;
    assign wb_adr_o      = adr_reg;
    assign wb_dat_o      = dat_reg;
    assign wb_sel_o      = sel_reg;
    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Bench for biquad8_coeff_loader: three parameterisations behind a selector,
// a latency-programmable ack responder and a write scoreboard.
`timescale 1ns/1ps
module tb_biquad8_coeff_loader;

    localparam int NINST = 3;

    typedef struct packed {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    typedef struct {
        string       name;
        int          inst;
        int          lat;
        int          never_idx;
        int          stall_after;
        int          stall_len;
        logic [17:0] base;
        bit          extra_start;
        int          exp_done;
        int          exp_err;
        int          exp_wr;
        int          exp_ctrl;
        int          exp_last_hi;
        int          gap_min;
        int          gap_max_lo;
        int          gap_max_hi;
        int          max_cyc;
    } case_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic        ack = 1'b0;
    logic [17:0] dat = '0;
    int          sel = 0;

    logic        start_v [NINST];
    logic        valid_v [NINST];
    logic        ack_v   [NINST];
    logic        ready_a [NINST];
    logic        cyc_a   [NINST];
    logic        stb_a   [NINST];
    logic        we_a    [NINST];
    logic        busy_a  [NINST];
    logic        done_a  [NINST];
    logic        err_a   [NINST];
    logic [6:0]  adr_a   [NINST];
    logic [31:0] dat_a   [NINST];
    logic [3:0]  sel_a   [NINST];

    always #5 clk = ~clk;

    // Instance 0: 8 coeffs + update, long timeout; 1: 3 coeffs + update,
    // TIMEOUT 15; 2: single coeff, no update, TIMEOUT 15.
    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        assign start_v[gi] = start && (sel == gi);
        assign valid_v[gi] = valid && (sel == gi);
        assign ack_v[gi]   = ack && (sel == gi);

        biquad8_coeff_loader #(
            .NCOEFF    ((gi == 0) ? 8 : (gi == 1) ? 3 : 1),
            .UPDATE_EN (gi != 2),
            .TIMEOUT   ((gi == 0) ? 1023 : 15)
        ) u_dut (
            .wb_clk_i      (clk),
            .wb_rst_i      (rst),
            .start_i       (start_v[gi]),
            .coeff_dat_i   (dat),
            .coeff_valid_i (valid_v[gi]),
            .coeff_ready_o (ready_a[gi]),
            .wb_cyc_o      (cyc_a[gi]),
            .wb_stb_o      (stb_a[gi]),
            .wb_we_o       (we_a[gi]),
            .wb_adr_o      (adr_a[gi]),
            .wb_dat_o      (dat_a[gi]),
            .wb_sel_o      (sel_a[gi]),
            .wb_ack_i      (ack_v[gi]),
            .busy_o        (busy_a[gi]),
            .done_o        (done_a[gi]),
            .err_o         (err_a[gi])
        );
    end

    logic        m_ready, m_cyc, m_stb, m_we, m_busy, m_done, m_err;
    logic [6:0]  m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    assign m_ready = ready_a[sel];
    assign m_cyc   = cyc_a[sel];
    assign m_stb   = stb_a[sel];
    assign m_we    = we_a[sel];
    assign m_busy  = busy_a[sel];
    assign m_done  = done_a[sel];
    assign m_err   = err_a[sel];
    assign m_adr   = adr_a[sel];
    assign m_dat   = dat_a[sel];
    assign m_sel   = sel_a[sel];

    int  n_chk = 0;
    int  n_fail = 0;
    int  lat = 1;
    int  never_idx = -1;
    int  wr_cnt, ctrl_cnt, done_cnt, err_cnt;
    int  hi_len, lo_len, last_hi, min_gap, max_gap;
    bit  prev_stb = 1'b0;
    bit  abort = 1'b0;
    wr_t held;
    wr_t sb[$];
    case_t cases[6];

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input bit ok, input logic [63:0] act);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, outside required range", name, act);
        end
    endtask

    // Bus monitor, scoreboard consumer and ack-driving target model.
    always @(negedge clk) begin
        wr_t got;
        wr_t want;
        if (rst) begin
            prev_stb = 1'b0;
            hi_len   = 0;
            lo_len   = 0;
            ack      = 1'b0;
        end else begin
            if (m_stb && !prev_stb) begin
                got = {m_adr, m_dat, m_sel};
                if (m_adr == 7'h04 && wr_cnt > 0) begin
                    if (lo_len < min_gap) min_gap = lo_len;
                    if (lo_len > max_gap) max_gap = lo_len;
                end
                if (sb.size() == 0) begin
                    chk_true("unexpected_write", 1'b0, 64'(got));
                end else begin
                    want = sb.pop_front();
                    chk_eq($sformatf("write%0d", wr_cnt), 64'({got, m_we, m_cyc}), 64'({want, 2'b11}));
                end
                $display("write %0d: adr=0x%02h dat=0x%08h sel=0x%0h", wr_cnt, m_adr, m_dat, m_sel);
                wr_cnt++;
                if (m_adr == 7'h00) ctrl_cnt++;
                held   = got;
                hi_len = 1;
            end else if (m_stb) begin
                hi_len++;
                chk_eq("hold_stable", 64'({m_adr, m_dat, m_sel, m_we, m_cyc}), 64'({held, 2'b11}));
            end else if (prev_stb) begin
                last_hi = hi_len;
                lo_len  = 1;
            end else begin
                lo_len++;
            end
            if (m_ready) chk_true("ready_only_fetch", !m_cyc && m_busy, 64'({m_cyc, m_busy}));
            if (m_done) done_cnt++;
            if (m_err) err_cnt++;
            prev_stb = m_stb;
            if (ack) ack = 1'b0;
            else if (m_stb && hi_len == lat && (wr_cnt - 1) != never_idx) ack = 1'b1;
        end
    end

    // Coefficient source: pushes the expected write whenever a beat will transfer.
    task automatic feed(input int n, input logic [17:0] base, input int stall_after,
                        input int stall_len, input bit upd);
        int i = 0;
        int stall = 0;
        int budget = 0;
        while (i < n && !abort && budget < 5000) begin
            @(negedge clk);
            budget++;
            if (stall > 0) begin
                valid = 1'b0;
                stall--;
            end else begin
                valid = 1'b1;
                dat   = base + 18'(i);
                if (m_ready && !rst) begin
                    sb.push_back('{adr: 7'h04, dat: {14'b0, dat}, sel: 4'hF});
                    i++;
                    if (i == stall_after) stall = stall_len;
                    if (i == n && upd) sb.push_back('{adr: 7'h00, dat: 32'h1, sel: 4'h1});
                end
            end
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic clear_stats();
        wr_cnt = 0; ctrl_cnt = 0; done_cnt = 0; err_cnt = 0;
        last_hi = 0; min_gap = 1 << 30; max_gap = 0; abort = 1'b0;
        sb.delete();
    endtask

    task automatic run_case(input case_t c);
        int t = 0;
        int n;
        bit upd;
        sel = c.inst;
        lat = c.lat;
        never_idx = c.never_idx;
        n   = (c.inst == 0) ? 8 : (c.inst == 1) ? 3 : 1;
        upd = (c.inst != 2);
        clear_stats();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        fork
            feed(n, c.base, c.stall_after, c.stall_len, upd);
            begin
                while (done_cnt + err_cnt == 0 && t < 3000) begin
                    @(negedge clk); #1; t++;
                end
                @(negedge clk); #1;
                chk_eq({c.name, "_busy_after"}, 64'(m_busy), 64'(0));
                abort = 1'b1;
            end
            begin
                if (c.extra_start) begin
                    repeat (30) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        repeat (4) @(negedge clk);
        #1;
        chk_eq({c.name, "_done"}, 64'(done_cnt), 64'(c.exp_done));
        chk_eq({c.name, "_err"}, 64'(err_cnt), 64'(c.exp_err));
        chk_eq({c.name, "_writes"}, 64'(wr_cnt), 64'(c.exp_wr));
        chk_eq({c.name, "_ctrl_writes"}, 64'(ctrl_cnt), 64'(c.exp_ctrl));
        chk_eq({c.name, "_last_stb_len"}, 64'(last_hi), 64'(c.exp_last_hi));
        chk_eq({c.name, "_sb_empty"}, 64'(sb.size()), 64'(0));
        if (c.gap_min > 0) begin
            // Between coefficient writes stb is low for GAP plus the FETCH handshake cycle.
            chk_eq({c.name, "_min_gap"}, 64'(min_gap), 64'(c.gap_min));
            chk_true({c.name, "_max_gap"}, max_gap >= c.gap_max_lo && max_gap <= c.gap_max_hi, 64'(max_gap));
        end
        if (c.max_cyc > 0)
            chk_true({c.name, "_latency"}, t <= c.max_cyc && t >= c.max_cyc - 40, 64'(t));
        $display("case %s: writes=%0d ctrl=%0d done=%0d err=%0d cycles=%0d", c.name, wr_cnt, ctrl_cnt, done_cnt, err_cnt, t);
    endtask

    initial begin
        int t;
        //            name       inst lat nev stA stL base      xs  dn er wr ct hi gmin gLo gHi maxc
        cases[0] = '{"normal",   0,  20, -1,  0,  0, 18'h00001, 0,  1, 0, 9, 1, 20, 2,  2,  2, 217};
        cases[1] = '{"stall",    0,   5, -1,  3, 50, 18'h2A000, 1,  1, 0, 9, 1,  5, 2, 40, 60,   0};
        cases[2] = '{"timeout",  1,   4,  1,  0,  0, 18'h00010, 0,  0, 1, 2, 0, 15, 2,  2,  2,   0};
        cases[3] = '{"boundary", 1,  15, -1,  0,  0, 18'h1FFFE, 0,  1, 0, 4, 1, 15, 2,  2,  2,   0};
        cases[4] = '{"single",   2,   3, -1,  0,  0, 18'h3FFFF, 0,  1, 0, 1, 0,  3, -1, 0,  0,   0};
        cases[5] = '{"restart",  0,  20, -1,  0,  0, 18'h00101, 1,  1, 0, 9, 1, 20, 2,  2,  2, 217};

        for (int s = 0; s < NINST; s++) begin
            sel = s;
            #1;
            chk_eq($sformatf("reset_state%0d", s),
                   64'({m_ready, m_cyc, m_stb, m_we, m_adr, m_dat, m_sel, m_busy, m_done, m_err}), 64'(0));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) run_case(cases[k]);

        // Asynchronous reset while the fourth coefficient write is on the bus.
        sel = 0; lat = 20; never_idx = -1;
        clear_stats();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        t = 0;
        fork
            feed(8, 18'h00100, 0, 0, 1'b1);
            begin
                while (!(wr_cnt == 4 && m_stb) && t < 2000) begin
                    @(negedge clk); #1; t++;
                end
                chk_true("rst_reach_write4", t < 2000, 64'(t));
                #2 rst = 1'b1;
                #1;
                chk_eq("rst_async_drop", 64'({m_cyc, m_stb, m_busy, m_ready}), 64'(0));
                abort = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        chk_eq("rst_no_pulse", 64'({done_cnt, err_cnt}), 64'(0));
        $display("reset: asserted during write %0d", wr_cnt);
        rst = 1'b0;
        run_case(cases[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
